// File: rtl/spi_video_rx.sv
// spi_video_rx: captures N 16-bit SPI video samples into a 128-word buffer and offers them as a 2N-byte message.
// Registered outputs; n_cs low for DIV+32*N*DIV cycles; the encoder paces readout with enc_rdreq, and requests are ignored while busy.
module spi_video_rx #(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  output logic       n_cs,
  output logic       sclk,
  input  logic       miso,
  input  logic [7:0] in_data,
  input  logic       in_ena,
  input  logic       enc_rdreq,
  output logic [7:0] out_data,
  output logic       have_msg,
  output logic [7:0] len,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEAD    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_TRAIL   = 3'd3;
  localparam logic [2:0] S_READOUT = 3'd4;
  localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [6:0]  wr_ptr_q, wr_ptr_d;
  logic [7:0]  rd_ptr_q, rd_ptr_d;
  logic [6:0]  n_q, n_d;
  logic        n_cs_q, n_cs_d;
  logic        sclk_q, sclk_d;
  logic        have_msg_q, have_msg_d;
  logic        busy_q, busy_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  out_data_q, out_data_d;

  logic [15:0] buf_mem [128];
  logic        phase_end;
  logic        take_sample;
  logic        wr_en;
  logic [15:0] wr_word;
  logic [15:0] rd_word;

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    n_d         = n_q;
    sclk_d      = sclk_q;
    take_sample = 1'b0;
    wr_en       = 1'b0;
    wr_word     = {shreg_q[14:0], miso};
    phase_end   = (div_cnt_q == DIV_LAST);

    case (state_q)
      S_IDLE: begin
        if (in_ena && (in_data != 8'd0) && !in_data[7]) begin
          n_d       = in_data[6:0];
          wr_ptr_d  = 7'd0;
          rd_ptr_d  = 8'd0;
          bit_cnt_d = 4'd0;
          div_cnt_d = 8'd0;
          state_d   = S_LEAD;
        end
      end
      S_LEAD: begin
        div_cnt_d = phase_end ? 8'd0 : div_cnt_q + 8'd1;
        if (phase_end) begin
          state_d     = S_SHIFT;
          take_sample = 1'b1;
        end
      end
      S_SHIFT: begin
        div_cnt_d = phase_end ? 8'd0 : div_cnt_q + 8'd1;
        // A low phase ending with every frame stored closes the burst.
        if (phase_end) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (wr_ptr_q == n_q) begin
            state_d = S_TRAIL;
          end else begin
            take_sample = 1'b1;
          end
        end
      end
      S_TRAIL: begin
        state_d = S_READOUT;
      end
      S_READOUT: begin
        if (enc_rdreq) begin
          rd_ptr_d = rd_ptr_q + 8'd1;
          if (rd_ptr_q == ({n_q, 1'b0} - 8'd1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // miso is captured on the same edge that raises sclk.
    if (take_sample) begin
      sclk_d    = 1'b1;
      shreg_d   = wr_word;
      bit_cnt_d = bit_cnt_q + 4'd1;
      if (bit_cnt_q == 4'd15) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 7'd1;
      end
    end

    n_cs_d     = !((state_d == S_LEAD) || (state_d == S_SHIFT));
    busy_d     = (state_d != S_IDLE);
    have_msg_d = (state_d == S_READOUT);
    len_d      = have_msg_d ? {n_d, 1'b0} : 8'd0;

    rd_word    = buf_mem[rd_ptr_d[7:1]];
    out_data_d = out_data_q;
    if (state_d == S_READOUT) begin
      out_data_d = rd_ptr_d[0] ? rd_word[7:0] : rd_word[15:8];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= 8'd0;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= 16'd0;
      wr_ptr_q   <= 7'd0;
      rd_ptr_q   <= 8'd0;
      n_q        <= 7'd0;
      n_cs_q     <= 1'b1;
      sclk_q     <= 1'b0;
      have_msg_q <= 1'b0;
      busy_q     <= 1'b0;
      len_q      <= 8'd0;
      out_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      n_q        <= n_d;
      n_cs_q     <= n_cs_d;
      sclk_q     <= sclk_d;
      have_msg_q <= have_msg_d;
      busy_q     <= busy_d;
      len_q      <= len_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[wr_ptr_q] <= wr_word;
    end
  end

  assign n_cs     = n_cs_q;
  assign sclk     = sclk_q;
  assign have_msg = have_msg_q;
  assign busy     = busy_q;
  assign len      = len_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_spi_video_rx.sv
// Bench for spi_video_rx: lane 0 runs DIV=2, lane 1 runs DIV=5, each with an SPI slave and a timing/data model.
module tb_spi_video_rx;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  logic [1:0]      n_cs_w, sclk_w, have_msg_w, busy_w;
  logic [1:0]      in_ena_w    = '0;
  logic [1:0]      enc_rdreq_w = '0;
  logic [1:0][7:0] in_data_w   = '0;
  logic [1:0][7:0] out_data_w, len_w;

  logic [15:0] frames [2][128];
  logic [7:0]  got [254];
  logic [7:0]  exp6 [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
  logic [7:0]  exp4 [4] = '{8'hF0, 8'h0F, 8'h12, 8'h34};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int g, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s lane=%0d got=%h want=%h", name, g, act, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int D = (g == 0) ? 2 : 5;
    logic miso = 1'b0;

    spi_video_rx #(.DIV(D)) u_dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .n_cs      (n_cs_w[g]),
      .sclk      (sclk_w[g]),
      .miso      (miso),
      .in_data   (in_data_w[g]),
      .in_ena    (in_ena_w[g]),
      .enc_rdreq (enc_rdreq_w[g]),
      .out_data  (out_data_w[g]),
      .have_msg  (have_msg_w[g]),
      .len       (len_w[g]),
      .busy      (busy_w[g])
    );

    // SPI slave: MSB of frame 0 on n_cs fall, next bit after every sclk fall.
    int   bi     = 0;
    logic p_ncs  = 1'b1;
    logic p_sclk = 1'b0;
    always @(posedge clk) begin
      #2;
      if (p_ncs && !n_cs_w[g]) bi = 0;
      else if (p_sclk && !sclk_w[g]) bi++;
      p_ncs  = n_cs_w[g];
      p_sclk = sclk_w[g];
      miso   = frames[g][(bi / 16) % 128][15 - (bi % 16)];
    end

    // Model: kk counts cycles since the accepted request; rd counts bytes consumed.
    int   mode = 0;
    int   kk   = 0;
    int   n    = 0;
    int   rd   = 0;
    logic [7:0] last_out = 8'h00;
    always @(posedge clk) begin
      int s_end;
      logic [15:0] w;
      logic e_ncs, e_sclk, e_busy, e_have;
      if (!n_rst) begin
        mode = 0; kk = 0; rd = 0; last_out = 8'h00;
      end else if (mode == 0) begin
        if (in_ena_w[g] && in_data_w[g] >= 8'd1 && in_data_w[g] <= 8'd127) begin
          mode = 1; kk = 1; n = int'(in_data_w[g]); rd = 0;
        end
      end else begin
        if (kk >= D + 32 * n * D + 2 && enc_rdreq_w[g]) begin
          rd++;
          if (rd == 2 * n) mode = 0;
        end
        kk++;
      end
      #1;
      if (n_rst) begin
        s_end  = D + 32 * n * D;
        e_ncs  = 1'b1;
        e_sclk = 1'b0;
        e_busy = (mode != 0);
        e_have = 1'b0;
        if (mode != 0) begin
          if (kk <= s_end) begin
            e_ncs  = 1'b0;
            e_sclk = (kk > D) && (((kk - D - 1) / D) % 2 == 0);
          end else if (kk > s_end + 1) begin
            e_have   = 1'b1;
            w        = frames[g][rd / 2];
            last_out = (rd % 2 == 0) ? w[15:8] : w[7:0];
          end
        end
        check("n_cs", g, 16'(n_cs_w[g]), 16'(e_ncs));
        check("sclk", g, 16'(sclk_w[g]), 16'(e_sclk));
        check("busy", g, 16'(busy_w[g]), 16'(e_busy));
        check("have_msg", g, 16'(have_msg_w[g]), 16'(e_have));
        check("out_data", g, 16'(out_data_w[g]), 16'(last_out));
        if (e_have) check("len", g, 16'(len_w[g]), 16'(2 * n));
      end
    end

    int low_cnt = 0, ncs_low_len = 0, hi_cnt = 0, hi_run = 0, lo_cnt = 0, lo_run = 0;
    always @(posedge clk) begin
      #1;
      if (!n_cs_w[g]) low_cnt++;
      else if (low_cnt != 0) begin ncs_low_len = low_cnt; low_cnt = 0; end
      if (sclk_w[g]) begin
        hi_cnt++;
        if (lo_cnt != 0) begin lo_run = lo_cnt; lo_cnt = 0; end
      end else begin
        if (hi_cnt != 0) begin hi_run = hi_cnt; hi_cnt = 0; end
        if (!n_cs_w[g]) lo_cnt++;
        else lo_cnt = 0;
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic request(input int g, input logic [7:0] v);
    @(negedge clk);
    in_data_w[g] = v;
    in_ena_w[g]  = 1'b1;
    @(negedge clk);
    in_ena_w[g]  = 1'b0;
  endtask

  task automatic read_one(input int g);
    enc_rdreq_w[g] = 1'b1;
    @(negedge clk);
    enc_rdreq_w[g] = 1'b0;
  endtask

  task automatic wait_have(input int g, input int limit);
    int c = 0;
    while (!have_msg_w[g] && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (!have_msg_w[g]) begin
      total++;
      bad++;
      $display("FAIL wait_have lane=%0d got have_msg=0 after %0d cycles want 1", g, limit);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 128; i++) frames[g][i] = 16'h0000;

    tick(3);
    n_rst = 1'b1;
    tick(1);
    check("rst_n_cs", 0, 16'(n_cs_w[0]), 16'd1);
    check("rst_sclk", 0, 16'(sclk_w[0]), 16'd0);
    check("rst_have", 0, 16'(have_msg_w[0]), 16'd0);
    check("rst_len", 0, 16'(len_w[0]), 16'd0);
    check("rst_out", 0, 16'(out_data_w[0]), 16'd0);
    check("rst_busy", 0, 16'(busy_w[0]), 16'd0);
    check("rst_busy", 1, 16'(busy_w[1]), 16'd0);

    // Single sample
    frames[0][0] = 16'h0ABC;
    request(0, 8'd1);
    check("start_busy", 0, 16'(busy_w[0]), 16'd1);
    check("start_n_cs", 0, 16'(n_cs_w[0]), 16'd0);
    wait_have(0, 200);
    check("ncs_low_len", 0, 16'(g_lane[0].ncs_low_len), 16'd66);
    check("single_len", 0, 16'(len_w[0]), 16'd2);
    check("single_b0", 0, 16'(out_data_w[0]), 16'h0A);
    read_one(0);
    check("single_b1", 0, 16'(out_data_w[0]), 16'hBC);
    check("single_have_mid", 0, 16'(have_msg_w[0]), 16'd1);
    read_one(0);
    check("single_have_end", 0, 16'(have_msg_w[0]), 16'd0);
    check("single_busy_end", 0, 16'(busy_w[0]), 16'd0);

    // Read strobes while idle
    repeat (3) read_one(0);
    check("idle_rdreq_out", 0, 16'(out_data_w[0]), 16'hBC);

    // Illegal requests
    request(0, 8'd0);
    request(0, 8'd128);
    tick(4);
    check("illegal_n_cs", 0, 16'(n_cs_w[0]), 16'd1);
    check("illegal_busy", 0, 16'(busy_w[0]), 16'd0);

    // Strobes during SHIFT and READOUT are ignored
    frames[0][0] = 16'hA1B2;
    frames[0][1] = 16'hC3D4;
    frames[0][2] = 16'hE5F6;
    request(0, 8'd3);
    tick(60);
    request(0, 8'd5);
    wait_have(0, 400);
    check("ign_len", 0, 16'(len_w[0]), 16'd6);
    request(0, 8'd7);
    check("ign_len_ro", 0, 16'(len_w[0]), 16'd6);
    check("ign_have_ro", 0, 16'(have_msg_w[0]), 16'd1);
    for (int i = 0; i < 6; i++) begin
      check("ign_byte", 0, 16'(out_data_w[0]), 16'(exp6[i]));
      read_one(0);
      tick(1);
    end
    check("ign_busy_end", 0, 16'(busy_w[0]), 16'd0);

    // Full burst with back-to-back reads
    for (int k = 0; k < 127; k++) frames[0][k] = 16'h1000 + 16'(k);
    request(0, 8'd127);
    wait_have(0, 9000);
    check("full_len", 0, 16'(len_w[0]), 16'd254);
    for (int i = 0; i < 254; i++) begin
      got[i] = out_data_w[0];
      enc_rdreq_w[0] = 1'b1;
      @(negedge clk);
    end
    enc_rdreq_w[0] = 1'b0;
    check("full_b0", 0, 16'(got[0]), 16'h10);
    check("full_b1", 0, 16'(got[1]), 16'h00);
    check("full_b3", 0, 16'(got[3]), 16'h01);
    check("full_b252", 0, 16'(got[252]), 16'h10);
    check("full_b253", 0, 16'(got[253]), 16'h7E);
    check("full_have_end", 0, 16'(have_msg_w[0]), 16'd0);
    check("full_busy_end", 0, 16'(busy_w[0]), 16'd0);

    // Reset in the middle of SHIFT
    for (int k = 0; k < 10; k++) frames[0][k] = 16'hC000 + 16'(k);
    request(0, 8'd10);
    tick(2 + 3 * 64 + 3);
    n_rst = 1'b0;
    #1;
    check("mrst_n_cs", 0, 16'(n_cs_w[0]), 16'd1);
    check("mrst_sclk", 0, 16'(sclk_w[0]), 16'd0);
    check("mrst_have", 0, 16'(have_msg_w[0]), 16'd0);
    check("mrst_busy", 0, 16'(busy_w[0]), 16'd0);
    tick(2);
    n_rst = 1'b1;
    tick(1);
    frames[0][0] = 16'h5A3C;
    request(0, 8'd1);
    wait_have(0, 200);
    check("post_rst_len", 0, 16'(len_w[0]), 16'd2);
    check("post_rst_b0", 0, 16'(out_data_w[0]), 16'h5A);
    read_one(0);
    check("post_rst_b1", 0, 16'(out_data_w[0]), 16'h3C);
    read_one(0);
    check("post_rst_have", 0, 16'(have_msg_w[0]), 16'd0);

    // Slow clock, DIV=5
    frames[1][0] = 16'hF00F;
    frames[1][1] = 16'h1234;
    request(1, 8'd2);
    wait_have(1, 800);
    check("slow_ncs_low", 1, 16'(g_lane[1].ncs_low_len), 16'd325);
    check("slow_hi_run", 1, 16'(g_lane[1].hi_run), 16'd5);
    check("slow_lo_run", 1, 16'(g_lane[1].lo_run), 16'd5);
    check("slow_len", 1, 16'(len_w[1]), 16'd4);
    for (int i = 0; i < 4; i++) begin
      check("slow_byte", 1, 16'(out_data_w[1]), 16'(exp4[i]));
      read_one(1);
    end
    check("slow_have_end", 1, 16'(have_msg_w[1]), 16'd0);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
